// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: header geometry, field widths and the frame-builder state encoding.
package eth_pkg;
    localparam int ETH_HDR_BYTES       = 14;
    localparam int ETH_MIN_FRAME_BYTES = 60;
    localparam int ETH_MAC_W           = 48;
    localparam int ETH_TYPE_W          = 16;
    localparam int ETH_HDR_W           = ETH_HDR_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD
    } tx_state_t;
endpackage

// File: rtl/eth_hdr_serializer.sv
// Captures the 14-byte Ethernet header on load and presents header byte idx_i (byte 0 = dst MAC MSB).
// Output is combinational from the capture register and the index; it is 0 for indices past the header.
module eth_hdr_serializer
    import eth_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [ETH_MAC_W-1:0]  dst_mac_i,
    input  logic [ETH_MAC_W-1:0]  src_mac_i,
    input  logic [ETH_TYPE_W-1:0] ethertype_i,
    input  logic [3:0]            idx_i,
    output logic [7:0]            byte_o
);
    logic [ETH_HDR_W-1:0] hdr_q;
    logic [ETH_HDR_W-1:0] hdr_d;
    logic [ETH_HDR_W-1:0] hdr_shifted;

    always_comb begin
        hdr_d = hdr_q;
        if (load_i) begin
            hdr_d = {dst_mac_i, src_mac_i, ethertype_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hdr_q <= '0;
        end else begin
            hdr_q <= hdr_d;
        end
    end

    // Shifting left brings the indexed byte to the top; indices 14/15 shift in zeros.
    assign hdr_shifted = hdr_q << {idx_i, 3'b000};
    assign byte_o      = hdr_shifted[ETH_HDR_W-1 -: 8];
endmodule

// File: rtl/eth_frame_builder.sv
// Serializes header + payload (+ zero pad to MIN_FRAME_BYTES) onto a byte AXI-Stream; header byte 0 one cycle after hdr accept.
// Payload is a zero-latency pass-through with tready forwarded upstream; header/pad bytes are held stable under backpressure.
module eth_frame_builder
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
    parameter bit PAD_EN          = 1'b1
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hdr_valid,
    output logic                  hdr_ready,
    input  logic [ETH_MAC_W-1:0]  hdr_dst_mac,
    input  logic [ETH_MAC_W-1:0]  hdr_src_mac,
    input  logic [ETH_TYPE_W-1:0] hdr_ethertype,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  tx_frame_start,
    output logic                  tx_frame_end,
    output logic                  tx_frame_padded
);
    localparam int              CW       = $clog2(MIN_FRAME_BYTES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(MIN_FRAME_BYTES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MIN_FRAME_BYTES - 1);
    localparam logic [CW-1:0]   HDR_LAST = CW'(ETH_HDR_BYTES - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]    hdr_byte;
    logic          hdr_load;
    logic          pad_needed;
    logic          out_acc;
    logic          hdr_rdy_c, s_rdy_c, tvalid_c, tlast_c;
    logic [7:0]    tdata_c;

    assign hdr_load = (state_q == ST_IDLE) && hdr_valid && !rst;

    eth_hdr_serializer u_hdr_ser (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (hdr_load),
        .dst_mac_i   (hdr_dst_mac),
        .src_mac_i   (hdr_src_mac),
        .ethertype_i (hdr_ethertype),
        .idx_i       (byte_cnt_q[3:0]),
        .byte_o      (hdr_byte)
    );

    // byte_cnt_q counts bytes already accepted, so the current beat is byte number byte_cnt_q+1.
    assign pad_needed = PAD_EN && (byte_cnt_q < CNT_LAST);

    always_comb begin
        hdr_rdy_c = 1'b0;
        s_rdy_c   = 1'b0;
        tvalid_c  = 1'b0;
        tlast_c   = 1'b0;
        tdata_c   = 8'h00;
        case (state_q)
            ST_IDLE: begin
                hdr_rdy_c = 1'b1;
            end
            ST_HEADER: begin
                tvalid_c = 1'b1;
                tdata_c  = hdr_byte;
            end
            ST_PAYLOAD: begin
                tvalid_c = s_axis_tvalid;
                tdata_c  = s_axis_tdata;
                s_rdy_c  = m_axis_tready;
                tlast_c  = s_axis_tlast && !pad_needed;
            end
            ST_PAD: begin
                tvalid_c = 1'b1;
                tlast_c  = (byte_cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    assign out_acc = tvalid_c && m_axis_tready;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        if (state_q == ST_IDLE) begin
            byte_cnt_d = '0;
        end else if (out_acc && (byte_cnt_q != CNT_MAX)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
        case (state_q)
            ST_IDLE:    if (hdr_valid) state_d = ST_HEADER;
            ST_HEADER:  if (out_acc && (byte_cnt_q == HDR_LAST)) state_d = ST_PAYLOAD;
            ST_PAYLOAD: if (out_acc && s_axis_tlast) state_d = pad_needed ? ST_PAD : ST_IDLE;
            ST_PAD:     if (out_acc && tlast_c) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Reset forces every output low, even though the state register only clears at the edge.
    assign hdr_ready       = hdr_rdy_c & ~rst;
    assign s_axis_tready   = s_rdy_c & ~rst;
    assign m_axis_tvalid   = tvalid_c & ~rst;
    assign m_axis_tlast    = tlast_c & ~rst;
    assign m_axis_tdata    = rst ? 8'h00 : tdata_c;
    assign tx_frame_start  = out_acc && (state_q == ST_HEADER) && (byte_cnt_q == '0) && !rst;
    assign tx_frame_end    = out_acc && tlast_c && !rst;
    assign tx_frame_padded = out_acc && tlast_c && (state_q == ST_PAD) && !rst;
endmodule
